// File: rtl/opcode_encoder.sv
// 6502 instruction encoder: turns a (cmd, address mode, operand) request into
// the opcode/operand byte stream over a valid/ready byte interface.
module opcode_encoder #(
  parameter int BRK_PAD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  cmd,
  input  logic [3:0]  address,
  input  logic [15:0] operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_first,
  output logic        out_last,
  output logic        err,
  output logic        busy
);

  localparam logic [3:0] M_IMPL = 4'd0,  M_A    = 4'd1,  M_IMM  = 4'd2,  M_ZPG  = 4'd3;
  localparam logic [3:0] M_ZPGX = 4'd4,  M_ZPGY = 4'd5,  M_ABS  = 4'd6,  M_ABSX = 4'd7;
  localparam logic [3:0] M_ABSY = 4'd8,  M_IND  = 4'd9,  M_XIND = 4'd10, M_INDY = 4'd11;
  localparam logic [3:0] M_REL  = 4'd12;
  localparam logic [5:0] C_BRK  = 6'h38;

  typedef enum logic [1:0] {IDLE = 2'd0, OPC = 2'd1, LO = 2'd2, HI = 2'd3} state_t;

  // cmd[5:3] picks the opcode-map group; cmd[2:0] is the aaa field (or row index).
  // Returns {legal, opcode}.
  function automatic logic [8:0] encode(input logic [5:0] c, input logic [3:0] m);
    logic [2:0] a;
    logic [2:0] aa;
    logic [2:0] b;
    logic       ok;
    logic [7:0] op;
    a  = c[2:0];
    aa = c[2:0];
    b  = 3'd0;
    ok = 1'b0;
    op = 8'h00;
    case (c[5:3])
      3'd0: begin
        ok = 1'b1;
        case (m)
          M_XIND:  b = 3'd0;
          M_ZPG:   b = 3'd1;
          M_IMM:   begin b = 3'd2; ok = (a != 3'd4); end
          M_ABS:   b = 3'd3;
          M_INDY:  b = 3'd4;
          M_ZPGX:  b = 3'd5;
          M_ABSY:  b = 3'd6;
          M_ABSX:  b = 3'd7;
          default: ok = 1'b0;
        endcase
        op = {a, b, 2'b01};
      end
      3'd1: begin
        ok = 1'b1;
        case (m)
          M_IMM:   begin b = 3'd0; ok = (a == 3'd5); end
          M_ZPG:   b = 3'd1;
          M_A:     begin b = 3'd2; ok = (a < 3'd4); end
          M_ABS:   b = 3'd3;
          M_ZPGX:  begin b = 3'd5; ok = (a < 3'd4) || (a > 3'd5); end
          M_ZPGY:  begin b = 3'd5; ok = (a == 3'd4) || (a == 3'd5); end
          M_ABSX:  begin b = 3'd7; ok = (a < 3'd4) || (a > 3'd5); end
          M_ABSY:  begin b = 3'd7; ok = (a == 3'd5); end
          default: ok = 1'b0;
        endcase
        op = {a, b, 2'b10};
      end
      3'd2: begin
        case (m)
          M_IMM:   begin b = 3'd0; ok = (a >= 3'd5); end
          M_ZPG:   begin b = 3'd1; ok = (a == 3'd1) || (a >= 3'd4); end
          M_ABS:   begin b = 3'd3; ok = (a == 3'd1) || (a == 3'd2) || (a >= 3'd4); end
          M_IND:   begin b = 3'd3; ok = (a == 3'd2); aa = 3'd3; end
          M_ZPGX:  begin b = 3'd5; ok = (a == 3'd4) || (a == 3'd5); end
          M_ABSX:  begin b = 3'd7; ok = (a == 3'd5); end
          default: ok = 1'b0;
        endcase
        op = {aa, b, 2'b00};
      end
      3'd3: begin ok = (m == M_REL);  op = {a, 5'b10000}; end
      3'd4: begin ok = (m == M_IMPL); op = {a, 5'b01000}; end
      3'd5: begin ok = (m == M_IMPL); op = {a, 5'b11000}; end
      3'd6: begin
        ok = (m == M_IMPL) && (a <= 3'd5);
        op = (a == 3'd5) ? 8'hEA : {1'b1, a, 4'b1010};
      end
      3'd7: begin
        case (a)
          3'd0:    begin ok = (m == M_IMPL); op = 8'h00; end
          3'd1:    begin ok = (m == M_ABS);  op = 8'h20; end
          3'd2:    begin ok = (m == M_IMPL); op = 8'h40; end
          3'd3:    begin ok = (m == M_IMPL); op = 8'h60; end
          default: begin ok = (m == M_IMPL) || (m == M_A); op = {1'b0, a[1:0], 5'b01010}; end
        endcase
      end
      default: ok = 1'b0;
    endcase
    return {ok, op};
  endfunction

  function automatic logic [1:0] byte_len(input logic [5:0] c, input logic [3:0] m);
    logic [1:0] n;
    if (c == C_BRK) begin
      n = (BRK_PAD != 0) ? 2'd2 : 2'd1;
    end else begin
      case (m)
        M_IMPL, M_A:                    n = 2'd1;
        M_ABS, M_ABSX, M_ABSY, M_IND:   n = 2'd3;
        default:                        n = 2'd2;
      endcase
    end
    return n;
  endfunction

  state_t      state, next_state;
  logic [7:0]  op_r, lo_r, hi_r;
  logic [1:0]  len_r;
  logic        err_r;
  logic [8:0]  enc;
  logic        accept;

  assign enc      = encode(cmd, address);
  assign accept   = in_valid & in_ready;
  assign in_ready = (state == IDLE) & ~rst;
  assign busy     = (state != IDLE);
  assign err      = err_r;

  // State, latched instruction and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r  <= 8'h00;
      lo_r  <= 8'h00;
      hi_r  <= 8'h00;
      len_r <= 2'd0;
      err_r <= 1'b0;
    end else begin
      state <= next_state;
      err_r <= accept & ~enc[8];
      if (accept && enc[8]) begin
        op_r  <= enc[7:0];
        lo_r  <= operand[7:0];
        hi_r  <= operand[15:8];
        len_r <= byte_len(cmd, address);
      end
    end
  end

  // Next-state and byte-interface outputs; fields only change on a transfer.
  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    out_byte   = 8'h00;
    out_first  = 1'b0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && enc[8]) next_state = OPC;
        else                  next_state = IDLE;
      end
      OPC: begin
        out_valid = 1'b1;
        out_byte  = op_r;
        out_first = 1'b1;
        out_last  = (len_r == 2'd1);
        if (out_ready) next_state = (len_r == 2'd1) ? IDLE : LO;
        else           next_state = OPC;
      end
      LO: begin
        out_valid = 1'b1;
        out_byte  = lo_r;
        out_last  = (len_r == 2'd2);
        if (out_ready) next_state = (len_r == 2'd2) ? IDLE : HI;
        else           next_state = LO;
      end
      HI: begin
        out_valid = 1'b1;
        out_byte  = hi_r;
        out_last  = 1'b1;
        if (out_ready) next_state = IDLE;
        else           next_state = HI;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_opcode_encoder.sv
// Directed bench for opcode_encoder: opcode map, lengths, stalls, errors, BRK padding, reset.
module tb_opcode_encoder;

  localparam logic [3:0] M_IMPL = 4'd0, M_A = 4'd1, M_IMM = 4'd2, M_ZPG = 4'd3, M_ZPGX = 4'd4;
  localparam logic [3:0] M_ZPGY = 4'd5, M_ABS = 4'd6, M_ABSX = 4'd7, M_ABSY = 4'd8, M_IND = 4'd9;
  localparam logic [3:0] M_XIND = 4'd10, M_INDY = 4'd11, M_REL = 4'd12;
  localparam logic [5:0] C_STA = 6'h04, C_LDA = 6'h05, C_ASL = 6'h08, C_JMP = 6'h12;
  localparam logic [5:0] C_BNE = 6'h1E, C_NOP = 6'h35, C_BRK = 6'h38;

  logic clk = 1'b0;
  logic rst, in_valid, in_valid0, out_ready;
  logic [5:0] cmd;
  logic [3:0] address;
  logic [15:0] operand;
  logic in_ready, out_valid, out_first, out_last, err, busy;
  logic [7:0] out_byte;
  logic in_ready0, out_valid0, out_first0, out_last0, err0, busy0;
  logic [7:0] out_byte0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opcode_encoder #(.BRK_PAD(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cmd(cmd), .address(address),
    .operand(operand), .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_first(out_first), .out_last(out_last), .err(err), .busy(busy));

  opcode_encoder #(.BRK_PAD(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .cmd(cmd), .address(address),
    .operand(operand), .out_valid(out_valid0), .out_ready(out_ready), .out_byte(out_byte0),
    .out_first(out_first0), .out_last(out_last0), .err(err0), .busy(busy0));

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [5:0] c, input logic [3:0] m, input logic [15:0] o);
    bit done = 1'b0;
    cmd = c; address = m; operand = o; in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      done = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin $display("FAIL send_timeout cmd=%h got no in_ready, required in_ready=1", c); errors++; end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b1;
    cmd = 6'h00; address = 4'h0; operand = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_byte, out_first, out_last, err, busy} !== 14'h0) begin
      $display("FAIL reset_outputs got %b required 0", {in_ready, out_valid, out_byte, out_first, out_last, err, busy}); errors++;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin $display("FAIL reset_release in_ready=%b busy=%b required 1/0", in_ready, busy); errors++; end
  endtask

  task automatic test_lda_imm;
    send(C_LDA, M_IMM, 16'h1242);
    checks++;
    if ({out_valid, out_byte, out_first, out_last, in_ready, busy} !== {1'b1, 8'hA9, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL lda_imm_opc got v=%b b=%h f=%b l=%b ir=%b required 1 a9 1 0 0", out_valid, out_byte, out_first, out_last, in_ready); errors++;
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_byte, out_first, out_last} !== {1'b1, 8'h42, 1'b0, 1'b1}) begin
      $display("FAIL lda_imm_lo got v=%b b=%h f=%b l=%b required 1 42 0 1", out_valid, out_byte, out_first, out_last); errors++;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL lda_imm_done got v=%b ir=%b busy=%b required 0 1 0", out_valid, in_ready, busy); errors++;
    end
  endtask

  task automatic test_stall;
    logic [7:0] exp_b [3];
    exp_b = '{8'h6C, 8'h34, 8'h12};
    out_ready = 1'b0;
    send(C_JMP, M_IND, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 3; s++) begin
        checks++;
        if ({out_valid, out_byte, out_first, out_last} !== {1'b1, exp_b[i], i == 0, i == 2}) begin
          $display("FAIL jmp_ind_stall byte%0d cyc%0d got v=%b b=%h f=%b l=%b required 1 %h %b %b",
                   i, s, out_valid, out_byte, out_first, out_last, exp_b[i], i == 0, i == 2); errors++;
        end
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL jmp_ind_done got v=%b ir=%b required 0 1", out_valid, in_ready); errors++; end
  endtask

  task automatic test_back_to_back;
    send(C_NOP, M_IMPL, 16'hFFFF);
    cmd = C_STA; address = M_ABSX; operand = 16'h0300; in_valid = 1'b1;
    checks++;
    if ({out_valid, out_byte, out_first, out_last, in_ready} !== {1'b1, 8'hEA, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL nop_byte got v=%b b=%h f=%b l=%b ir=%b required 1 ea 1 1 0", out_valid, out_byte, out_first, out_last, in_ready); errors++;
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin $display("FAIL b2b_bubble got ir=%b v=%b required 1 0", in_ready, out_valid); errors++; end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_byte, out_first, out_last} !== {1'b1, 8'h9D, 1'b1, 1'b0}) begin
      $display("FAIL sta_absx_opc got v=%b b=%h f=%b l=%b required 1 9d 1 0", out_valid, out_byte, out_first, out_last); errors++;
    end
    @(negedge clk);
    checks++;
    if ({out_byte, out_last} !== {8'h00, 1'b0} || out_valid !== 1'b1) begin $display("FAIL sta_absx_lo got b=%h l=%b required 00 0", out_byte, out_last); errors++; end
    @(negedge clk);
    checks++;
    if ({out_byte, out_last} !== {8'h03, 1'b1} || out_valid !== 1'b1) begin $display("FAIL sta_absx_hi got b=%h l=%b required 03 1", out_byte, out_last); errors++; end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    logic [5:0] ic [7];
    logic [3:0] im [7];
    ic = '{C_STA, C_ASL, C_JMP, C_NOP, C_BNE, 6'h10, 6'h36};
    im = '{M_IMM, M_IMM, M_ZPG, M_ABS, M_ABS, M_ZPG, M_IMPL};
    for (int i = 0; i < 7; i++) begin
      send(ic[i], im[i], 16'h5555);
      checks++;
      if ({err, out_valid, busy, in_ready} !== 4'b1001) begin
        $display("FAIL illegal_%0d err/v/busy/ir got %b required 1001", i, {err, out_valid, busy, in_ready}); errors++;
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || out_valid !== 1'b0) begin $display("FAIL illegal_pulse_%0d err=%b v=%b required 0 0", i, err, out_valid); errors++; end
    end
    send(C_LDA, M_ZPG, 16'h0080);
    checks++;
    if ({out_byte, out_first, err} !== {8'hA5, 1'b1, 1'b0}) begin $display("FAIL after_err_opc got b=%h f=%b err=%b required a5 1 0", out_byte, out_first, err); errors++; end
    @(negedge clk);
    checks++;
    if ({out_byte, out_last} !== {8'h80, 1'b1}) begin $display("FAIL after_err_lo got b=%h l=%b required 80 1", out_byte, out_last); errors++; end
    @(negedge clk);
  endtask

  task automatic test_opcodes;
    logic [5:0] tc [17];
    logic [3:0] tm [17];
    logic [7:0] to [17];
    int         tl [17];
    tc = '{6'h0D, 6'h0C, 6'h0B, 6'h3F, 6'h0F, 6'h17, 6'h11, 6'h1E, 6'h31, 6'h2D, 6'h23, 6'h39, 6'h07, 6'h00, 6'h0A, 6'h15, 6'h12};
    tm = '{M_ABSY, M_ZPGY, M_A, M_IMPL, M_ABSX, M_IMM, M_ABS, M_REL, M_IMPL, M_IMPL, M_IMPL, M_ABS, M_INDY, M_XIND, M_ZPGX, M_ABSX, M_ABS};
    to = '{8'hBE, 8'h96, 8'h6A, 8'h6A, 8'hFE, 8'hE0, 8'h2C, 8'hD0, 8'h9A, 8'hB8, 8'h68, 8'h20, 8'hF1, 8'h01, 8'h56, 8'hBC, 8'h4C};
    tl = '{3, 2, 1, 1, 3, 2, 3, 2, 1, 1, 1, 3, 2, 2, 2, 3, 3};
    for (int i = 0; i < 17; i++) begin
      send(tc[i], tm[i], 16'hBEEF);
      checks++;
      if ({out_valid, out_byte, out_first, out_last} !== {1'b1, to[i], 1'b1, tl[i] == 1}) begin
        $display("FAIL opcode_%0d got v=%b b=%h f=%b l=%b required 1 %h 1 %b", i, out_valid, out_byte, out_first, out_last, to[i], tl[i] == 1); errors++;
      end
      for (int k = 1; k < tl[i]; k++) begin
        @(negedge clk);
        checks++;
        if ({out_valid, out_byte, out_first, out_last} !== {1'b1, (k == 1) ? 8'hEF : 8'hBE, 1'b0, k == tl[i] - 1}) begin
          $display("FAIL operand_%0d_%0d got v=%b b=%h l=%b", i, k, out_valid, out_byte, out_last); errors++;
        end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin $display("FAIL length_%0d out_valid got %b required 0", i, out_valid); errors++; end
    end
  endtask

  task automatic test_brk;
    send(C_BRK, M_IMPL, 16'h00FF);
    checks++;
    if ({out_byte, out_first, out_last} !== {8'h00, 1'b1, 1'b0} || out_valid !== 1'b1) begin
      $display("FAIL brk_pad_opc got b=%h f=%b l=%b required 00 1 0", out_byte, out_first, out_last); errors++;
    end
    @(negedge clk);
    checks++;
    if ({out_byte, out_first, out_last} !== {8'hFF, 1'b0, 1'b1} || out_valid !== 1'b1) begin
      $display("FAIL brk_pad_byte got b=%h f=%b l=%b required ff 0 1", out_byte, out_first, out_last); errors++;
    end
    @(negedge clk);
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    checks++;
    if ({out_valid0, out_byte0, out_first0, out_last0} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      $display("FAIL brk_nopad got v=%b b=%h f=%b l=%b required 1 00 1 1", out_valid0, out_byte0, out_first0, out_last0); errors++;
    end
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin $display("FAIL brk_nopad_len got v=%b ir=%b required 0 1", out_valid0, in_ready0); errors++; end
  endtask

  task automatic test_mid_reset;
    send(C_LDA, M_ABS, 16'h1234);
    checks++;
    if (out_byte !== 8'hAD) begin $display("FAIL lda_abs_opc got %h required ad", out_byte); errors++; end
    @(negedge clk);
    checks++;
    if (out_byte !== 8'h34 || out_last !== 1'b0) begin $display("FAIL lda_abs_lo got b=%h l=%b required 34 0", out_byte, out_last); errors++; end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin $display("FAIL rst_in_ready got %b required 0", in_ready); errors++; end
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_byte, out_first, out_last, err, busy} !== 14'h0) begin
      $display("FAIL mid_reset_outputs got %b required 0", {in_ready, out_valid, out_byte, out_first, out_last, err, busy}); errors++;
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin $display("FAIL post_reset_%0d got ir=%b v=%b b=%h required 1 0", k, in_ready, out_valid, out_byte); errors++; end
    end
  endtask

  initial begin
    test_reset();
    test_lda_imm();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_opcodes();
    test_brk();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
